// File: rtl/video_timing_pkg.sv
// Shared FSM states, raster regions and 1080p60 defaults
// for the video timing controller.
package video_timing_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } region_t;

  localparam int DefBusWidth = 12;
  localparam int DefHActive  = 1920;
  localparam int DefHFront   = 88;
  localparam int DefHSync    = 44;
  localparam int DefHBack    = 148;
  localparam int DefVActive  = 1080;
  localparam int DefVFront   = 4;
  localparam int DefVSync    = 5;
  localparam int DefVBack    = 36;

  function automatic region_t region_f(
    input int unsigned count,
    input int unsigned active,
    input int unsigned front,
    input int unsigned sync
  );
    region_t r;
    if (count < active)
      r = ACTIVE;
    else if (count < active + front)
      r = FRONT;
    else if (count < active + front + sync)
      r = SYNC;
    else
      r = BACK;
    return r;
  endfunction

endpackage

// File: rtl/video_timing_ctrl_if.sv
// Raster bundle between the timing controller and its consumers.
// OVERLAY_WINDOW_EN adds the overlay window inputs and winActive.
interface video_timing_if #(
  parameter int busWidth = 12
);

  logic                run;
  logic [busWidth-1:0] hCount;
  logic [busWidth-1:0] vCount;
  logic                hsyncOut;
  logic                vsyncOut;
  logic                deOut;
  logic                frameStart;
  logic                lineStart;
  logic                busy;

`ifdef OVERLAY_WINDOW_EN
  logic [busWidth-1:0] winX;
  logic [busWidth-1:0] winY;
  logic [busWidth-1:0] winW;
  logic [busWidth-1:0] winH;
  logic                winActive;

  modport master (
    input  run, winX, winY, winW, winH,
    output hCount, vCount, hsyncOut, vsyncOut,
    output deOut, frameStart, lineStart, busy,
    output winActive
  );

  modport slave (
    output run, winX, winY, winW, winH,
    input  hCount, vCount, hsyncOut, vsyncOut,
    input  deOut, frameStart, lineStart, busy,
    input  winActive
  );
`else
  modport master (
    input  run,
    output hCount, vCount, hsyncOut, vsyncOut,
    output deOut, frameStart, lineStart, busy
  );

  modport slave (
    output run,
    input  hCount, vCount, hsyncOut, vsyncOut,
    input  deOut, frameStart, lineStart, busy
  );
`endif

endinterface

// File: rtl/raster_axis_counter.sv
// One raster axis: wrap-at-total counter with advance enable
// and the region of the value it will hold after this edge.
module raster_axis_counter
  import video_timing_pkg::*;
#(
  parameter int busWidth = 12,
  parameter int active   = 1920,
  parameter int front    = 88,
  parameter int sync     = 44,
  parameter int back     = 148
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                advance,
  output logic [busWidth-1:0] count,
  output logic [busWidth-1:0] countNext,
  output logic                atLast,
  output region_t             regionNext
);

  localparam int total = active + front + sync + back;
  localparam logic [busWidth-1:0] lastVal = busWidth'(total - 1);

  assign atLast = count == lastVal;

  always_comb begin
    countNext = count;
    if (advance)
      countNext = atLast ? '0 : count + 1'b1;
    regionNext = region_f(32'(countNext), active, front, sync);
  end

  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else
      count <= countNext;
  end

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster sequencer: counters, syncs, DE and strobes, halting on frame edges.
// OVERLAY_WINDOW_EN adds a frame-latched overlay window flag.
module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int busWidth = DefBusWidth,
  parameter int hActive  = DefHActive,
  parameter int hFront   = DefHFront,
  parameter int hSync    = DefHSync,
  parameter int hBack    = DefHBack,
  parameter int vActive  = DefVActive,
  parameter int vFront   = DefVFront,
  parameter int vSync    = DefVSync,
  parameter int vBack    = DefVBack,
  parameter bit syncPol  = 1'b1
) (
  input logic clock,
  input logic reset,
  video_timing_if.master vid
);

  state_t              state;
  state_t              stateNext;
  logic [busWidth-1:0] hNext;
  logic [busWidth-1:0] vNext;
  logic                hLast;
  logic                vLast;
  region_t             hRegNext;
  region_t             vRegNext;
  logic                runNow;
  logic                runNext;
  logic                deNext;
  logic                fsNext;
  logic                lsNext;

  assign runNow = state == RUN;

  raster_axis_counter #(
    .busWidth(busWidth), .active(hActive),
    .front(hFront), .sync(hSync), .back(hBack)
  ) hAxis (
    .clock      (clock),
    .reset      (reset),
    .advance    (runNow),
    .count      (vid.hCount),
    .countNext  (hNext),
    .atLast     (hLast),
    .regionNext (hRegNext)
  );

  raster_axis_counter #(
    .busWidth(busWidth), .active(vActive),
    .front(vFront), .sync(vSync), .back(vBack)
  ) vAxis (
    .clock      (clock),
    .reset      (reset),
    .advance    (runNow && hLast),
    .count      (vid.vCount),
    .countNext  (vNext),
    .atLast     (vLast),
    .regionNext (vRegNext)
  );

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= stateNext;
  end

  // run only matters on the last pixel, so frames are never cut short
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (vid.run) stateNext = RUN;
      RUN:  if (hLast && vLast && !vid.run) stateNext = IDLE;
    endcase
    runNext = stateNext == RUN;
    deNext  = runNext && hRegNext == ACTIVE && vRegNext == ACTIVE;
    lsNext  = runNext && hNext == '0;
    fsNext  = lsNext && vNext == '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vid.deOut      <= 1'b0;
      vid.frameStart <= 1'b0;
      vid.lineStart  <= 1'b0;
      vid.busy       <= 1'b0;
      vid.hsyncOut   <= ~syncPol;
      vid.vsyncOut   <= ~syncPol;
    end else begin
      vid.deOut      <= deNext;
      vid.frameStart <= fsNext;
      vid.lineStart  <= lsNext;
      vid.busy       <= runNext;
      vid.hsyncOut   <= (runNext && hRegNext == SYNC) ? syncPol : ~syncPol;
      vid.vsyncOut   <= (runNext && vRegNext == SYNC) ? syncPol : ~syncPol;
    end
  end

`ifdef OVERLAY_WINDOW_EN
  logic [busWidth-1:0] wX, wY, wW, wH;
  logic [busWidth-1:0] eX, eY, eW, eH;
  logic                winNext;

  // window inputs are only taken on the frameStart edge
  always_comb begin
    {eX, eY, eW, eH} = {wX, wY, wW, wH};
    if (fsNext)
      {eX, eY, eW, eH} = {vid.winX, vid.winY, vid.winW, vid.winH};
    winNext = deNext
      && hNext >= eX
      && {1'b0, hNext} < {1'b0, eX} + {1'b0, eW}
      && vNext >= eY
      && {1'b0, vNext} < {1'b0, eY} + {1'b0, eH};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      {wX, wY, wW, wH} <= '0;
      vid.winActive    <= 1'b0;
    end else begin
      {wX, wY, wW, wH} <= {eX, eY, eW, eH};
      vid.winActive    <= winNext;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Scoreboard bench for video_timing_ctrl on a 14x7 raster,
// with an inverted-polarity instance run in lockstep.
module tb_video_timing_ctrl;

  localparam int BW = 4;

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] v;
    logic de;
    logic hs;
    logic vs;
    logic fs;
    logic ls;
    logic busy;
    logic hsN;
    logic vsN;
    logic win;
  } obs_t;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  video_timing_if #(.busWidth(BW)) vid ();
  video_timing_if #(.busWidth(BW)) vidN ();

  video_timing_ctrl #(
    .busWidth(BW), .hActive(8), .hFront(2), .hSync(2), .hBack(2),
    .vActive(4), .vFront(1), .vSync(1), .vBack(1), .syncPol(1'b1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .vid   (vid)
  );

  video_timing_ctrl #(
    .busWidth(BW), .hActive(8), .hFront(2), .hSync(2), .hBack(2),
    .vActive(4), .vFront(1), .vSync(1), .vBack(1), .syncPol(1'b0)
  ) dutN (
    .clock (clock),
    .reset (reset),
    .vid   (vidN)
  );

  int   tests = 0;
  int   fails = 0;
  obs_t q[$];

  int eh = 0;
  int ev = 0;
  bit eBusy = 1'b0;

  int wx = 0, wy = 0, ww = 0, wh = 0;
  int lx = 0, ly = 0, lw = 0, lh = 0;

  int n;
  int deSeen, hsSeen, vsSeen, lsSeen, fsSeen;
  int fsFirst, fsSecond;
  int winCnt;

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // drive one cycle and queue the outputs the next edge must produce
  task automatic cyc(input logic r, input logic rst);
    obs_t e;
    vid.run  = r;
    vidN.run = r;
    reset    = rst;
`ifdef OVERLAY_WINDOW_EN
    vid.winX  = 4'(wx); vid.winY  = 4'(wy);
    vid.winW  = 4'(ww); vid.winH  = 4'(wh);
    vidN.winX = 4'(wx); vidN.winY = 4'(wy);
    vidN.winW = 4'(ww); vidN.winH = 4'(wh);
`endif
    if (rst) begin
      eBusy = 1'b0; eh = 0; ev = 0;
      lx = 0; ly = 0; lw = 0; lh = 0;
    end else if (!eBusy) begin
      if (r) eBusy = 1'b1;
    end else if (eh == 13 && ev == 6) begin
      eh = 0; ev = 0;
      if (!r) eBusy = 1'b0;
    end else if (eh == 13) begin
      eh = 0; ev = ev + 1;
    end else begin
      eh = eh + 1;
    end
    e.h    = 4'(eh);
    e.v    = 4'(ev);
    e.busy = eBusy;
    e.de   = eBusy && eh < 8 && ev < 4;
    e.hs   = eBusy && (eh == 10 || eh == 11);
    e.vs   = eBusy && ev == 5;
    e.fs   = eBusy && eh == 0 && ev == 0;
    e.ls   = eBusy && eh == 0;
    e.hsN  = !e.hs;
    e.vsN  = !e.vs;
    if (e.fs) begin
      lx = wx; ly = wy; lw = ww; lh = wh;
    end
`ifdef OVERLAY_WINDOW_EN
    e.win = e.de && eh >= lx && eh < lx + lw && ev >= ly && ev < ly + lh;
`else
    e.win = 1'b0;
`endif
    q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic runTo(input int h, input int v, input logic r);
    int k;
    k = 0;
    while (!(eBusy && eh == h && ev == v) && k < 200) begin
      cyc(r, 1'b0);
      k++;
    end
    check($sformatf("reach_%0d_%0d", h, v), int'(eh == h && ev == v), 1);
  endtask

`ifdef OVERLAY_WINDOW_EN
  task automatic frameWin(output int cnt);
    cnt = 0;
    for (int i = 0; i < 98; i++) begin
      cyc(1'b1, 1'b0);
      if (vid.winActive) cnt++;
    end
  endtask
`endif

  always @(negedge clock) begin
    obs_t e;
    obs_t a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a.h    = vid.hCount;
      a.v    = vid.vCount;
      a.de   = vid.deOut;
      a.hs   = vid.hsyncOut;
      a.vs   = vid.vsyncOut;
      a.fs   = vid.frameStart;
      a.ls   = vid.lineStart;
      a.busy = vid.busy;
      a.hsN  = vidN.hsyncOut;
      a.vsN  = vidN.vsyncOut;
`ifdef OVERLAY_WINDOW_EN
      a.win  = vid.winActive;
`else
      a.win  = 1'b0;
`endif
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL raster t=%0t: got h=%0d v=%0d de,hs,vs,fs,ls,busy,hsN,vsN,win=%b want h=%0d v=%0d flags=%b",
                 $time, a.h, a.v, a[8:0], e.h, e.v, e[8:0]);
      end
    end
  end

  initial begin
    reset = 1'b1;
    vid.run = 1'b0;
    vidN.run = 1'b0;

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    check("start_fs", int'(vid.frameStart), 1);
    runTo(13, 0, 1'b1);
    cyc(1'b1, 1'b0);
    check("wrap_h", int'(vid.hCount), 0);
    check("wrap_v", int'(vid.vCount), 1);

    runTo(13, 6, 1'b1);
    deSeen = 0; hsSeen = 0; vsSeen = 0; lsSeen = 0; fsSeen = 0;
    fsFirst = -1; fsSecond = -1;
    for (int i = 0; i < 294; i++) begin
      cyc(1'b1, 1'b0);
      if (vid.deOut) deSeen++;
      if (vid.hsyncOut) hsSeen++;
      if (vid.vsyncOut) vsSeen++;
      if (vid.lineStart) lsSeen++;
      if (vid.frameStart) begin
        fsSeen++;
        if (fsFirst < 0) fsFirst = i;
        else if (fsSecond < 0) fsSecond = i;
      end
    end
    check("de_cycles", deSeen, 96);
    check("hs_cycles", hsSeen, 42);
    check("vs_cycles", vsSeen, 42);
    check("ls_count", lsSeen, 21);
    check("fs_count", fsSeen, 3);
    check("fs_period", fsSecond - fsFirst, 98);

    runTo(3, 1, 1'b1);
    n = 0;
    do begin
      cyc(1'b0, 1'b0);
      n++;
    end while (eBusy && n < 200);
    check("stop_len", n, 81);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
    check("idle_busy", int'(vid.busy), 0);
    cyc(1'b1, 1'b0);
    check("restart_fs", int'(vid.frameStart), 1);

    runTo(9, 2, 1'b1);
    cyc(1'b1, 1'b1);
    check("midreset_h", int'(vid.hCount), 0);
    check("midreset_busy", int'(vid.busy), 0);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);

`ifdef OVERLAY_WINDOW_EN
    wx = 2; wy = 1; ww = 3; wh = 2;
    runTo(13, 6, 1'b1);
    frameWin(winCnt);
    check("win_6", winCnt, 6);
    runTo(5, 3, 1'b1);
    wx = 0; wy = 0; ww = 8; wh = 4;
    runTo(13, 6, 1'b1);
    frameWin(winCnt);
    check("win_full", winCnt, 32);
    ww = 0;
    frameWin(winCnt);
    check("win_w0", winCnt, 0);
`endif

    repeat (2) @(posedge clock);
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
